id_ex_issue: RTL

ID_EX_ISSUE -- requirements
Module: id_ex_issue

---
 rtl/id_ex_issue.sv | 153 +++++++++++++++
 1 files changed

// File: rtl/id_ex_issue.sv
// id_ex_issue: MIPS decode into a 2-entry in-order issue skid buffer.
// Option: DEC_ILLEGAL_TRAP_EN drops unsupported instrs and raises illegal.
module id_ex_issue (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [3:0]  aluctl,
  output logic [31:0] a,
  output logic [31:0] b,
  output logic [4:0]  rd,
  output logic        illegal
);

  typedef struct packed {
    logic [3:0]  ctl;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
  } op_t;

  logic [5:0]  opc;
  logic [5:0]  fn;
  logic [31:0] sext;
  logic [31:0] zext;
  logic [31:0] shamt;
  logic        rty;
  op_t         dec;
  logic        dec_ok;

  op_t         q0;
  op_t         q1;
  logic [1:0]  count;
  logic        acc;
  logic        push;
  logic        pop;

  // Register indices are already resolved into rs_val/rt_val.
  logic unused_idx;
  assign unused_idx = ^instr[25:21];

  assign opc   = instr[31:26];
  assign fn    = instr[5:0];
  assign sext  = {{16{instr[15]}}, instr[15:0]};
  assign zext  = {16'd0, instr[15:0]};
  assign shamt = {27'd0, instr[10:6]};
  assign rty   = (opc == 6'h00);

  // Decode the incoming instruction into an ALU op bundle.
  always_comb begin
    dec    = '{ctl: 4'hF, a: rs_val, b: rt_val, rd: 5'd0};
    dec_ok = 1'b1;
    unique case (1'b1)
      rty && fn == 6'h24:
        dec = '{4'd0, rs_val, rt_val, instr[15:11]};
      rty && fn == 6'h25:
        dec = '{4'd1, rs_val, rt_val, instr[15:11]};
      rty && (fn == 6'h20 || fn == 6'h21):
        dec = '{4'd2, rs_val, rt_val, instr[15:11]};
      rty && (fn == 6'h22 || fn == 6'h23):
        dec = '{4'd6, rs_val, rt_val, instr[15:11]};
      rty && fn == 6'h2A:
        dec = '{4'd7, rs_val, rt_val, instr[15:11]};
      rty && fn == 6'h26:
        dec = '{4'd12, rs_val, rt_val, instr[15:11]};
      rty && fn == 6'h00:
        dec = '{4'd3, rt_val, shamt, instr[15:11]};
      rty && fn == 6'h02:
        dec = '{4'd4, rt_val, shamt, instr[15:11]};
      rty && fn == 6'h03:
        dec = '{4'd5, rt_val, shamt, instr[15:11]};
      opc == 6'h08 || opc == 6'h09:
        dec = '{4'd2, rs_val, sext, instr[20:16]};
      opc == 6'h0A:
        dec = '{4'd7, rs_val, sext, instr[20:16]};
      opc == 6'h0C:
        dec = '{4'd0, rs_val, zext, instr[20:16]};
      opc == 6'h0D:
        dec = '{4'd1, rs_val, zext, instr[20:16]};
      opc == 6'h0E:
        dec = '{4'd12, rs_val, zext, instr[20:16]};
      opc == 6'h04:
        dec = '{4'd8, rs_val, rt_val, 5'd0};
      default:
        dec_ok = 1'b0;
    endcase
  end

  // Ready depends on the registered count only.
  assign in_ready  = (count < 2'd2);
  assign out_valid = (count != 2'd0);
  assign acc       = in_valid && in_ready;
  assign pop       = out_valid && out_ready;

`ifdef DEC_ILLEGAL_TRAP_EN
  logic ill_q;

  assign push    = acc && dec_ok;
  assign illegal = ill_q;

  // Sticky trap flag; unsupported ops are swallowed, not enqueued.
  always_ff @(posedge clk) begin
    if (!rst_n)
      ill_q <= 1'b0;
    else if (flush)
      ill_q <= 1'b0;
    else if (acc && !dec_ok)
      ill_q <= 1'b1;
  end
`else
  logic unused_ok;

  assign unused_ok = dec_ok;
  assign push      = acc;
  assign illegal   = 1'b0;
`endif

  // q0 is the head and keeps the last popped op while empty.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= 2'd0;
      q0    <= '0;
      q1    <= '0;
    end else if (flush) begin
      count <= 2'd0;
    end else begin
      if (push && (count == 2'd0 ||
                   (count == 2'd1 && pop)))
        q0 <= dec;
      else if (pop && count == 2'd2)
        q0 <= q1;
      if (push && count == 2'd1 && !pop)
        q1 <= dec;
      unique case ({push, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  assign aluctl = q0.ctl;
  assign a      = q0.a;
  assign b      = q0.b;
  assign rd     = q0.rd;

endmodule
